// File: rtl/pong_game_ctrl.sv
// Per-frame game sequencer for VGA pong: ball motion, wall/paddle collisions,
// scoring and the IDLE/SERVE/PLAY/OVER state machine. All outputs registered.
module pong_game_ctrl #(
  parameter int HRES         = 640,
  parameter int VRES         = 480,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_XL    = 16,
  parameter int PADDLE_XR    = 616,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [10:0] paddle_l_y,
  input  logic [10:0] paddle_r_y,
  output logic [11:0] ball_x,
  output logic [10:0] ball_y,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic [1:0]  state,
  output logic        game_over
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3} state_t;

  localparam int SCW = $clog2(SERVE_FRAMES);

  // Geometry widened by one bit so compares never wrap.
  localparam logic [12:0] HRES_X  = 13'(HRES);
  localparam logic [12:0] BS_X    = 13'(BALL_SIZE);
  localparam logic [12:0] SP_X    = 13'(BALL_SPEED);
  localparam logic [12:0] XL_EDGE = 13'(PADDLE_XL + PADDLE_W);
  localparam logic [12:0] XR_EDGE = 13'(PADDLE_XR);
  localparam logic [11:0] VRES_Y  = 12'(VRES);
  localparam logic [11:0] BS_Y    = 12'(BALL_SIZE);
  localparam logic [11:0] SP_Y    = 12'(BALL_SPEED);
  localparam logic [11:0] PH_Y    = 12'(PADDLE_H);
  localparam logic [11:0] CX      = 12'((HRES - BALL_SIZE) / 2);
  localparam logic [10:0] CY      = 11'((VRES - BALL_SIZE) / 2);
  localparam logic [3:0]  WIN_S   = 4'(WIN_SCORE);
  localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_FRAMES - 1);

  state_t         state_reg, state_next;
  logic [11:0]    ball_x_reg, ball_x_next;
  logic [10:0]    ball_y_reg, ball_y_next;
  logic           dx_reg, dx_next;       // 1 = moving right
  logic           dy_reg, dy_next;       // 1 = moving down
  logic [3:0]     score_l_reg, score_l_next;
  logic [3:0]     score_r_reg, score_r_next;
  logic [SCW-1:0] serve_cnt_reg, serve_cnt_next;
  logic           game_over_reg, game_over_next;

  logic [12:0] x_w;
  logic [11:0] y_w;
  logic [11:0] pad_w [2];
  logic [1:0]  overlap;

  assign x_w      = {1'b0, ball_x_reg};
  assign y_w      = {1'b0, ball_y_reg};
  assign pad_w[0] = {1'b0, paddle_l_y};
  assign pad_w[1] = {1'b0, paddle_r_y};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_overlap
      assign overlap[gi] = (y_w + BS_Y > pad_w[gi]) && (y_w < pad_w[gi] + PH_Y);
    end
  endgenerate

  // Candidate motion for one PLAY tick, evaluated from the current position.
  logic [10:0] y_n;
  logic        dy_n;
  logic [11:0] x_n;
  logic        dx_n;
  logic        miss_l, miss_r;

  always_comb begin
    y_n  = ball_y_reg;
    dy_n = dy_reg;
    if (!dy_reg) begin
      if (y_w < SP_Y) begin
        y_n  = '0;
        dy_n = 1'b1;
      end else begin
        y_n = 11'(y_w - SP_Y);
      end
    end else begin
      if (y_w + BS_Y + SP_Y > VRES_Y) begin
        y_n  = 11'(VRES_Y - BS_Y);
        dy_n = 1'b0;
      end else begin
        y_n = 11'(y_w + SP_Y);
      end
    end
  end

  always_comb begin
    x_n    = ball_x_reg;
    dx_n   = dx_reg;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (!dx_reg) begin
      // x - speed <= edge rewritten as x <= edge + speed to avoid underflow
      if ((x_w <= XL_EDGE + SP_X) && (x_w >= XL_EDGE) && overlap[0]) begin
        x_n  = 12'(XL_EDGE);
        dx_n = 1'b1;
      end else if (x_w < SP_X) begin
        miss_l = 1'b1;
        dx_n   = 1'b0;
      end else begin
        x_n = 12'(x_w - SP_X);
      end
    end else begin
      if ((x_w + BS_X + SP_X >= XR_EDGE) && (x_w + BS_X <= XR_EDGE) && overlap[1]) begin
        x_n  = 12'(XR_EDGE - BS_X);
        dx_n = 1'b0;
      end else if (x_w + BS_X + SP_X > HRES_X) begin
        miss_r = 1'b1;
        dx_n   = 1'b1;
      end else begin
        x_n = 12'(x_w + SP_X);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    ball_x_next    = ball_x_reg;
    ball_y_next    = ball_y_reg;
    dx_next        = dx_reg;
    dy_next        = dy_reg;
    score_l_next   = score_l_reg;
    score_r_next   = score_r_reg;
    serve_cnt_next = serve_cnt_reg;
    case (state_reg)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_next     = S_SERVE;
          score_l_next   = '0;
          score_r_next   = '0;
          serve_cnt_next = '0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_reg == SERVE_LAST) begin
            state_next     = S_PLAY;
            serve_cnt_next = '0;
          end else begin
            serve_cnt_next = serve_cnt_reg + 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          ball_x_next = x_n;
          ball_y_next = y_n;
          dx_next     = dx_n;
          dy_next     = dy_n;
          if (miss_l || miss_r) begin
            ball_x_next    = CX;
            ball_y_next    = CY;
            serve_cnt_next = '0;
            if (miss_l) begin
              score_r_next = score_r_reg + 4'd1;
              state_next   = (score_r_reg + 4'd1 == WIN_S) ? S_OVER : S_SERVE;
            end else begin
              score_l_next = score_l_reg + 4'd1;
              state_next   = (score_l_reg + 4'd1 == WIN_S) ? S_OVER : S_SERVE;
            end
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    game_over_next = (state_next == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      ball_x_reg    <= CX;
      ball_y_reg    <= CY;
      dx_reg        <= 1'b1;
      dy_reg        <= 1'b1;
      score_l_reg   <= '0;
      score_r_reg   <= '0;
      serve_cnt_reg <= '0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ball_x_reg    <= ball_x_next;
      ball_y_reg    <= ball_y_next;
      dx_reg        <= dx_next;
      dy_reg        <= dy_next;
      score_l_reg   <= score_l_next;
      score_r_reg   <= score_r_next;
      serve_cnt_reg <= serve_cnt_next;
      game_over_reg <= game_over_next;
    end
  end

  assign ball_x    = ball_x_reg;
  assign ball_y    = ball_y_reg;
  assign score_l   = score_l_reg;
  assign score_r   = score_r_reg;
  assign state     = state_reg;
  assign game_over = game_over_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a behavioural game model queues the expected
// outputs for every clock, a monitor pops and compares; directed spot checks on top.
module tb_pong_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [10:0] paddle_l_y = '0;
  logic [10:0] paddle_r_y = '0;
  logic [11:0] ball_x;
  logic [10:0] ball_y;
  logic [3:0]  score_l, score_r;
  logic [1:0]  state;
  logic        game_over;

  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
    .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, x, y, sl, sr, go;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state (value after the most recent modelled clock edge)
  int m_st, m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_cnt, m_go;
  int n_bl, n_br;
  bit trk_l, trk_r;

  task automatic model_reset();
    m_st = 0; m_x = 316; m_y = 236; m_dx = 1; m_dy = 1;
    m_sl = 0; m_sr = 0; m_cnt = 0; m_go = 0;
  endtask

  task automatic model_step();
    int nx, ny, ndx, ndy, pl, pr;
    bit ovl, ovr, ml, mr;
    if (rst) begin
      model_reset();
      return;
    end
    pl = int'(paddle_l_y);
    pr = int'(paddle_r_y);
    case (m_st)
      0, 3: if (start) begin m_st = 1; m_sl = 0; m_sr = 0; m_cnt = 0; end
      1: if (frame_tick) begin
        if (m_cnt == 59) begin m_st = 2; m_cnt = 0; end
        else m_cnt = m_cnt + 1;
      end
      2: if (frame_tick) begin
        ndy = m_dy; ndx = m_dx; ml = 0; mr = 0;
        if (m_dy == 0) begin
          if (m_y < 2) begin ny = 0; ndy = 1; end else ny = m_y - 2;
        end else begin
          if (m_y + 10 > 480) begin ny = 472; ndy = 0; end else ny = m_y + 2;
        end
        ovl = (m_y + 8 > pl) && (m_y < pl + 64);
        ovr = (m_y + 8 > pr) && (m_y < pr + 64);
        nx = m_x;
        if (m_dx == 0) begin
          if (m_x - 2 <= 24 && m_x >= 24 && ovl) begin nx = 24; ndx = 1; n_bl++; end
          else if (m_x < 2) begin ml = 1; ndx = 0; end
          else nx = m_x - 2;
        end else begin
          if (m_x + 10 >= 616 && m_x + 8 <= 616 && ovr) begin nx = 608; ndx = 0; n_br++; end
          else if (m_x + 10 > 640) begin mr = 1; ndx = 1; end
          else nx = m_x + 2;
        end
        m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
        if (ml || mr) begin
          m_x = 316; m_y = 236; m_cnt = 0;
          if (ml) m_sr = m_sr + 1; else m_sl = m_sl + 1;
          m_st = (m_sl == 9 || m_sr == 9) ? 3 : 1;
          $display("point: score_l=%0d score_r=%0d state=%0d", m_sl, m_sr, m_st);
        end
      end
      default: m_st = 0;
    endcase
    m_go = (m_st == 3) ? 1 : 0;
  endtask

  function automatic int pad_for(bit trk);
    int p;
    if (trk) begin
      p = m_y - 28;
      if (p < 0) p = 0;
      if (p > 416) p = 416;
    end else begin
      p = (m_y < 240) ? 400 : 0;
    end
    return p;
  endfunction

  // Inputs change at negedge; the expectation refers to the following posedge.
  task automatic drive(input bit rs, input bit st, input bit tk);
    exp_t e;
    @(negedge clk);
    rst = rs; start = st; frame_tick = tk;
    model_step();
    e.st = m_st; e.x = m_x; e.y = m_y; e.sl = m_sl; e.sr = m_sr; e.go = m_go;
    q.push_back(e);
  endtask

  // One frame: tick, then paddles repositioned while no tick is pending.
  task automatic frame();
    drive(0, 0, 1);
    @(negedge clk);
    paddle_l_y = 11'(pad_for(trk_l));
    paddle_r_y = 11'(pad_for(trk_r));
    rst = 0; start = 0; frame_tick = 0;
    begin
      exp_t e;
      model_step();
      e.st = m_st; e.x = m_x; e.y = m_y; e.sl = m_sl; e.sr = m_sr; e.go = m_go;
      q.push_back(e);
    end
    drive(0, 0, 0);
    drive(0, 0, 0);
    @(posedge clk); #2;
  endtask

  task automatic dchk(input string nm, input int st, input int x, input int y,
                      input int sl, input int sr, input int go);
    checks++;
    if (int'(state) !== st || int'(ball_x) !== x || int'(ball_y) !== y ||
        int'(score_l) !== sl || int'(score_r) !== sr || int'(game_over) !== go) begin
      errors++;
      $display("FAIL %s: got st=%0d x=%0d y=%0d sl=%0d sr=%0d go=%0d, want st=%0d x=%0d y=%0d sl=%0d sr=%0d go=%0d",
               nm, state, ball_x, ball_y, score_l, score_r, game_over, st, x, y, sl, sr, go);
    end else begin
      $display("check %s: st=%0d ball=(%0d,%0d) score=%0d:%0d", nm, state, ball_x, ball_y, score_l, score_r);
    end
  endtask

  task automatic budget_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: frame budget expired, score %0d:%0d state %0d", nm, m_sl, m_sr, m_st);
  endtask

  // Monitor: every cycle the DUT presents a new registered output set.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (int'(state) !== e.st || int'(ball_x) !== e.x || int'(ball_y) !== e.y ||
          int'(score_l) !== e.sl || int'(score_r) !== e.sr || int'(game_over) !== e.go) begin
        errors++;
        $display("FAIL cycle%0d: got st=%0d x=%0d y=%0d sl=%0d sr=%0d go=%0d, want st=%0d x=%0d y=%0d sl=%0d sr=%0d go=%0d",
                 cyc, state, ball_x, ball_y, score_l, score_r, game_over,
                 e.st, e.x, e.y, e.sl, e.sr, e.go);
      end
    end
  end

  initial begin
    int b;
    model_reset();
    n_bl = 0; n_br = 0;
    trk_l = 1; trk_r = 1;
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 1);                          // tick in IDLE does nothing
    @(posedge clk); #2;
    dchk("reset", 0, 316, 236, 0, 0, 0);

    drive(0, 1, 0);
    @(posedge clk); #2;
    dchk("start_to_serve", 1, 316, 236, 0, 0, 0);
    for (int i = 0; i < 59; i++) frame();
    dchk("serve_59_ticks", 1, 316, 236, 0, 0, 0);
    frame();
    dchk("serve_to_play", 2, 316, 236, 0, 0, 0);

    frame();
    dchk("play_first_tick", 2, 318, 238, 0, 0, 0);
    drive(0, 1, 0);                          // start ignored in PLAY
    for (int i = 0; i < 6; i++) drive(0, 0, 0);
    @(posedge clk); #2;
    dchk("no_tick_hold", 2, 318, 238, 0, 0, 0);

    // Rally until the left paddle has returned the ball once.
    b = 0;
    while (n_bl < 1 && b < 1000) begin frame(); b++; end
    if (n_bl < 1) budget_fail("left_bounce");
    else dchk("left_bounce", 2, m_x, m_y, 0, 0, 0);
    if (n_br < 1) budget_fail("right_bounce");

    // Left player stops defending: one left miss.
    trk_l = 0;
    b = 0;
    while (m_sr < 1 && b < 1000) begin frame(); b++; end
    if (m_sr < 1) budget_fail("left_miss");
    else dchk("left_miss", 1, 316, 236, 0, 1, 0);

    // Right player stops defending: left player runs to WIN_SCORE.
    trk_l = 1; trk_r = 0;
    b = 0;
    while (m_st != 3 && b < 3000) begin frame(); b++; end
    if (m_st != 3) budget_fail("game_over");
    else dchk("game_over", 3, 316, 236, 9, 1, 1);
    frame();
    dchk("over_hold", 3, 316, 236, 9, 1, 1);

    drive(0, 1, 1);                          // start wins over tick in OVER
    @(posedge clk); #2;
    dchk("restart", 1, 316, 236, 0, 0, 0);
    for (int i = 0; i < 63; i++) frame();
    dchk("replay", 2, m_x, m_y, 0, 0, 0);

    drive(1, 1, 1);                          // reset dominates
    @(posedge clk); #2;
    dchk("rst_mid_play", 0, 316, 236, 0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    @(posedge clk); #2;

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
